output_layer_sequencer: RTL and testbench

Time-multiplexed controller for the 128→3 output layer of the network. It replaces the fully parallel single-cycle dot product with one shared multiply-accumulate. The block walks the input buffer, weight ROM and bias ROM, then emits one fixed-point output per neuron on a valid strobe. It sits between the last hidden layer's activation buffer and the result register file, and is started once per inference.

---
 rtl/nn_pkg.sv | 31 +++
 rtl/mac_unit.sv | 44 ++++
 rtl/output_layer_sequencer.sv | 124 ++++++++++++
 tb/tb_output_layer_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the network layer sequencers.
// Sizes are fixed for the 128->3 output layer; hidden-layer sequencers reuse the same package.
package nn_pkg;

  localparam int unsigned N_IN  = 128;
  localparam int unsigned N_OUT = 3;
  localparam int unsigned DW    = 9;
  localparam int unsigned ACC_W = 30;
  localparam int unsigned SHIFT = 9;

  localparam int unsigned PROD_W = 2 * DW;
  localparam int unsigned IN_AW  = $clog2(N_IN);
  localparam int unsigned W_AW   = $clog2(N_IN * N_OUT);
  localparam int unsigned B_AW   = $clog2(N_OUT);

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StDrain,
    StBias,
    StWrite
  } seq_state_e;

  // Scale the accumulator back to data width; wraps rather than saturates.
  function automatic logic [DW-1:0] scale_out(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> SHIFT;
    return shifted[DW-1:0];
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Shared signed multiply-accumulate with clear and a bias-add path.
// acc_nxt is exposed so the sequencer can capture the biased sum in the same cycle it is formed.
module mac_unit
  import nn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    add_bias,
  input  logic [DW-1:0]           a,
  input  logic [DW-1:0]           b,
  input  logic [DW-1:0]           bias,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] acc_nxt
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;

  always_comb begin
    prod     = $signed(a) * $signed(b);
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    bias_ext = {{(ACC_W - DW){bias[DW-1]}}, bias};
    acc_nxt  = acc;
    if (clr) begin
      acc_nxt = '0;
    end else if (add_bias) begin
      acc_nxt = acc + bias_ext;
    end else if (en) begin
      acc_nxt = acc + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/output_layer_sequencer.sv
// Time-multiplexed 128->3 output layer: walks input buffer, weight ROM and bias ROM through
// one shared MAC and emits one scaled result per neuron with a valid strobe.
module output_layer_sequencer
  import nn_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [IN_AW-1:0] in_addr,
  input  logic [DW-1:0]   in_data,
  output logic [W_AW-1:0] w_addr,
  input  logic [DW-1:0]   w_data,
  output logic [B_AW-1:0] b_addr,
  input  logic [DW-1:0]   b_data,
  output logic            out_valid,
  output logic [B_AW-1:0] out_idx,
  output logic [DW-1:0]   out_data
);

  seq_state_e              state;
  logic [IN_AW-1:0]        j;
  logic [B_AW-1:0]         i;
  logic                    rd_vld;
  logic                    mac_clr;
  logic                    mac_en;
  logic                    mac_bias;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    last_j;
  logic                    last_i;

  assign in_addr = j;
  assign b_addr  = i;
  assign last_j  = (j == IN_AW'(N_IN - 1));
  assign last_i  = (i == B_AW'(N_OUT - 1));

  // Data for an issue arrives one cycle later, flagged by rd_vld.
  always_comb begin
    mac_clr  = ((state == StIdle) && start) || (state == StWrite);
    mac_en   = rd_vld;
    mac_bias = (state == StBias);
  end

  mac_unit u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (mac_clr),
    .en       (mac_en),
    .add_bias (mac_bias),
    .a        (in_data),
    .b        (w_data),
    .bias     (b_data),
    .acc      (acc),
    .acc_nxt  (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      j         <= '0;
      i         <= '0;
      w_addr    <= '0;
      rd_vld    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      rd_vld    <= (state == StMac);
      out_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state  <= StMac;
            j      <= '0;
            i      <= '0;
            w_addr <= '0;
            busy   <= 1'b1;
          end
        end
        StMac: begin
          if (last_j) begin
            state <= StDrain;
          end else begin
            j      <= j + IN_AW'(1);
            w_addr <= w_addr + W_AW'(N_OUT);
          end
        end
        StDrain: begin
          state <= StBias;
        end
        StBias: begin
          // Capture the biased sum as it lands so the strobe and data share the WRITE cycle.
          state     <= StWrite;
          out_valid <= 1'b1;
          out_idx   <= i;
          out_data  <= scale_out(acc_nxt);
          done      <= last_i;
        end
        StWrite: begin
          j <= '0;
          if (last_i) begin
            state  <= StIdle;
            i      <= '0;
            w_addr <= '0;
            busy   <= 1'b0;
          end else begin
            state  <= StMac;
            i      <= i + B_AW'(1);
            w_addr <= W_AW'(i) + W_AW'(1);
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_layer_sequencer.sv
// Self-checking bench for output_layer_sequencer: ROM models, reference dot-product model and
// a scoreboard of expected (index, data, cycle) tuples consumed on out_valid.
module tb_output_layer_sequencer;
  import nn_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic [IN_AW-1:0] in_addr;
  logic [DW-1:0]    in_data;
  logic [W_AW-1:0]  w_addr;
  logic [DW-1:0]    w_data;
  logic [B_AW-1:0]  b_addr;
  logic [DW-1:0]    b_data;
  logic             out_valid;
  logic [B_AW-1:0]  out_idx;
  logic [DW-1:0]    out_data;

  output_layer_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] in_mem [N_IN];
  logic signed [DW-1:0] w_mem  [N_IN*N_OUT];
  logic signed [DW-1:0] b_mem  [N_OUT];

  always @(posedge clk) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr];
    b_data  <= b_mem[b_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [B_AW-1:0] idx;
    logic [DW-1:0]   data;
    int              at;
    bit              last;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_valid = 0;

  function automatic logic [DW-1:0] model(input int i);
    longint acc;
    acc = 0;
    for (int j = 0; j < N_IN; j++) acc += longint'(in_mem[j]) * longint'(w_mem[j*N_OUT+i]);
    acc += longint'(b_mem[i]);
    acc = acc >>> SHIFT;
    return acc[DW-1:0];
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      n_valid++;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: got idx=%0d data=%h, expected no output", out_idx,
                 out_data);
      end else begin
        e = sb.pop_front();
        if (out_idx !== e.idx || out_data !== e.data)
          $display("FAIL out_value: got idx=%0d data=%h, expected idx=%0d data=%h", out_idx,
                   out_data, e.idx, e.data);
        else n_pass++;
        n_total++;
        if (cyc !== e.at || done !== e.last)
          $display("FAIL out_timing: got cycle=%0d done=%b, expected cycle=%0d done=%b", cyc,
                   done, e.at, e.last);
        else n_pass++;
      end
    end else if (done) begin
      n_total++;
      $display("FAIL done_without_valid: got done=1 at cycle %0d, expected 0", cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic fill(input int mode);
    for (int j = 0; j < N_IN; j++) begin
      case (mode)
        0:       in_mem[j] = 9'sd1;
        1:       in_mem[j] = 9'sd64;
        2:       in_mem[j] = -9'sd1;
        default: in_mem[j] = DW'($urandom_range(0, 511));
      endcase
    end
    for (int k = 0; k < N_IN*N_OUT; k++) begin
      case (mode)
        0:       w_mem[k] = 9'sd1;
        1:       w_mem[k] = 9'sd64;
        2:       w_mem[k] = 9'sd2;
        default: w_mem[k] = DW'($urandom_range(0, 511));
      endcase
    end
    for (int i = 0; i < N_OUT; i++) begin
      case (mode)
        0:       b_mem[i] = 9'sd0;
        1:       b_mem[i] = (i == 1) ? 9'sd256 : 9'sd0;
        2:       b_mem[i] = -9'sd3;
        default: b_mem[i] = DW'($urandom_range(0, 511));
      endcase
    end
  endtask

  // Called at a negedge: start is high for this cycle, accepted at the next edge (cycle 0).
  task automatic launch(output int base);
    exp_t e;
    base  = cyc;
    start = 1'b1;
    for (int i = 0; i < N_OUT; i++) begin
      e.idx  = B_AW'(i);
      e.data = model(i);
      e.at   = base + 131 * (i + 1);
      e.last = (i == N_OUT - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rel(input int base, input int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, out_valid, out_idx, out_data} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b idx=%0d data=%h, expected 0",
               busy, done, out_valid, out_idx, out_data);
    else n_pass++;
    n_total++;
    if ({in_addr, w_addr, b_addr} !== '0)
      $display("FAIL reset_addrs: got in=%0d w=%0d b=%0d, expected 0", in_addr, w_addr, b_addr);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones;
    int base;
    fill(0);
    launch(base);
    n_total++;
    if (busy !== 1'b1 || in_addr !== 7'd0 || w_addr !== 9'd0)
      $display("FAIL first_issue: got busy=%b in=%0d w=%0d, expected 1 0 0", busy, in_addr,
               w_addr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (in_addr !== 7'd1 || w_addr !== 9'd3)
      $display("FAIL second_issue: got in=%0d w=%0d, expected 1 3", in_addr, w_addr);
    else n_pass++;
    wait_rel(base, 132);
    n_total++;
    if (in_addr !== 7'd0 || w_addr !== 9'd1 || b_addr !== 2'd1)
      $display("FAIL neuron1_issue: got in=%0d w=%0d b=%0d, expected 0 1 1", in_addr, w_addr,
               b_addr);
    else n_pass++;
    wait_rel(base, 393);
    n_total++;
    if (busy !== 1'b1 || done !== 1'b1)
      $display("FAIL done_cycle: got busy=%b done=%b, expected 1 1", busy, done);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || out_idx !== 2'd2 || out_data !== 9'h000)
      $display("FAIL after_run: got busy=%b done=%b idx=%0d data=%h, expected 0 0 2 000", busy,
               done, out_idx, out_data);
    else n_pass++;
    n_total++;
    if (sb.size() != 0) $display("FAIL ones_drained: got %0d pending, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_pattern(input int mode);
    int base;
    fill(mode);
    @(negedge clk);
    launch(base);
    wait_rel(base, 394);
    n_total++;
    if (busy !== 1'b0 || sb.size() != 0)
      $display("FAIL pattern%0d_end: got busy=%b pending=%0d, expected 0 0", mode, busy,
               sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int base;
    int base2;
    int v0;
    fill(3);
    @(negedge clk);
    launch(base);
    wait_rel(base, 200);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({busy, done, out_valid, out_idx, out_data} !== '0)
      $display("FAIL midreset_outputs: got busy=%b done=%b valid=%b idx=%0d data=%h, expected 0",
               busy, done, out_valid, out_idx, out_data);
    else n_pass++;
    v0 = n_valid;
    wait_rel(base, 205);
    n_total++;
    if (n_valid != v0 || busy !== 1'b0)
      $display("FAIL midreset_quiet: got valids=%0d busy=%b, expected 0 0", n_valid - v0, busy);
    else n_pass++;
    launch(base2);
    wait_rel(base2, 393);
    n_total++;
    if (done !== 1'b1) $display("FAIL restart_done: got done=%b, expected 1", done);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || sb.size() != 0 || n_valid - v0 != 3)
      $display("FAIL restart_end: got busy=%b pending=%0d valids=%0d, expected 0 0 3", busy,
               sb.size(), n_valid - v0);
    else n_pass++;
  endtask

  task automatic test_start_ignored;
    int base;
    int v0;
    fill(3);
    v0 = n_valid;
    @(negedge clk);
    launch(base);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(base, 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(base, 393);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL ignored_busy394: got busy=%b, expected 0", busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || n_valid - v0 != 3 || sb.size() != 0)
      $display("FAIL ignored_end: got busy=%b valids=%0d pending=%0d, expected 0 3 0", busy,
               n_valid - v0, sb.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int base;
    int base2;
    int low_cnt;
    fill(3);
    @(negedge clk);
    launch(base);
    wait_rel(base, 394);
    n_total++;
    if (busy !== 1'b0) $display("FAIL b2b_busy394: got busy=%b, expected 0", busy);
    else n_pass++;
    fill(3);
    while (sb.size() != 0) void'(sb.pop_front());
    launch(base2);
    low_cnt = 0;
    for (int n = 1; n <= 393; n++) begin
      wait_rel(base2, n);
      if (busy !== 1'b1) low_cnt++;
    end
    n_total++;
    if (low_cnt != 0) $display("FAIL b2b_busy: got %0d low cycles, expected 0", low_cnt);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || sb.size() != 0)
      $display("FAIL b2b_end: got busy=%b pending=%0d, expected 0 0", busy, sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ones();
    test_pattern(1);
    test_pattern(2);
    test_pattern(3);
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
